// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for the elastic pipeline stage: upstream valid/ready,
// downstream valid/ready, pipeline flush and the occupancy report.
interface pipe_stage_elastic_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
);
  logic                       flush;
  logic                       in_valid;
  logic [WIDTH-1:0]           in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] occupancy;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// DEPTH-deep chain of valid-tagged pipeline registers with valid/ready
// handshakes, bubble collapsing, synchronous flush and occupancy count.
module pipe_stage_elastic #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic                clk,
  input logic                reset,
  pipe_stage_elastic_if.slave bus
);
  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] move;
  logic [OW-1:0]    occ;

  // A stage may load when it is empty or everything ahead of it is draining.
  always_comb begin
    logic m;
    move = '0;
    m = bus.out_ready | ~v[DEPTH-1];
    move[DEPTH-1] = m;
    for (int i = DEPTH-2; i >= 0; i--) begin
      m = ~v[i] | m;
      move[i] = m;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
    end else if (bus.flush) begin
      v <= '0;
    end else begin
      if (move[0]) begin
        v[0] <= bus.in_valid;
        if (bus.in_valid) data[0] <= bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (move[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) data[i] <= data[i-1];
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + OW'(v[i]);
  end

  assign bus.in_ready  = move[0] & ~bus.flush;
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];
  assign bus.occupancy = occ;
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor of the single 32-bit pipeline register: a DEPTH-deep chain of WIDTH-bit registers, each stage carrying a valid bit.
- Uses valid/ready handshakes on both sides, collapses bubbles, supports a synchronous flush and reports occupancy.
- Sits between pipeline units (e.g. IF/ID, ID/EX) of the processor, so a stalled downstream unit back-pressures cleanly and a branch flush kills in-flight entries.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 1, number of register stages (>=1). DEPTH=1 is the classic single pipeline register plus handshake.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every data register on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  synchronous kill of all in-flight entries.
- in_valid  input  1  upstream presents in_data.
- in_data  input  WIDTH  payload from upstream.
- in_ready  output  1  stage accepts in_data this cycle.
- out_valid  output  1  valid bit of the last stage.
- out_data  output  WIDTH  data register of the last stage.
- out_ready  input  1  downstream consumes out_data this cycle.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (reset==0, asynchronous):
  - All valid bits clear and all data registers = RESET_VAL, immediately and independent of clk.
  - Hence out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1.
  - Deassertion takes effect at the next rising edge.
- Stage index: 0 is the input side, DEPTH-1 is the output side.
- move[DEPTH-1] = out_ready | ~v[DEPTH-1].
- move[i] = ~v[i] | move[i+1] for i < DEPTH-1. This is a combinational chain, so bubbles collapse: a stage may load whenever it is empty or it is emptying.
- in_ready = move[0] & ~flush.
- Stage 0 loads in_data and sets v[0]=in_valid when move[0] & ~flush.
- Stage i>0 loads data[i-1] and v[i-1] when move[i] & ~flush.
- Data registers load only when the stage's new valid bit is 1. An empty stage keeps its old data (no toggling on bubbles).
- Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- Latency: with out_ready held 1 and no flush, data accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1, i.e. DEPTH cycles of register delay. Throughput is 1 per cycle.
- Back-pressure:
  - With out_ready=0 and all stages valid: in_ready=0, and contents and out_data are stable.
  - An empty stage still fills while out_ready=0, so up to DEPTH entries are absorbed.
- Flush:
  - At the edge with flush=1, all v[] clear. Data registers hold their values.
  - in_ready=0 during flush, so nothing is accepted that cycle.
  - An out transfer the same cycle is still counted by the downstream; flush only kills what remains.
  - Next cycle: occupancy=0, out_valid=0.
- Flush asserted during reset: reset wins.
- occupancy = popcount(v[]), registered-derived (no combinational path from the in_* or out_* handshake inputs). Range 0..DEPTH.
- Simultaneous in and out transfer when full: allowed (in_ready=1 because move propagates from out_ready). Occupancy is unchanged.
- out_valid must not depend combinationally on in_valid. in_ready may depend combinationally on out_ready.
- Reset asserted mid-stream: all entries are lost with no partial outputs. After release, behaviour is as if from power-up.

Test Plan:
- Reset: reset=0 with WIDTH=32, DEPTH=3, RESET_VAL=32'hDEAD_BEEF, held 2 cycles -> out_valid=0, out_data=32'hDEADBEEF, occupancy=0, in_ready=1. Releasing reset between edges changes nothing until the next edge.
- Streaming: out_ready=1, push 32'h1,32'h2,32'h3,32'h4 on consecutive cycles -> 32'h1 on out_data with out_valid=1 exactly 3 edges after acceptance, then 2,3,4 on the following cycles with no gaps.
- Back-pressure fill: out_ready=0, push 5 words -> first 3 accepted, in_ready=0 from the 4th, occupancy=3. Raising out_ready then drains 1,2,3 in order, with in_ready=1 in the same cycle as each pop.
- Bubble collapse: push 32'hA, idle 2 cycles, push 32'hB, with out_ready=0 -> occupancy=2 and 32'hA in the last stage. After out_ready=1, 32'hA and 32'hB come out on back-to-back cycles.
- Flush: occupancy=3, assert flush with in_valid=1 and in_data=32'hF -> in_ready=0 that cycle. Next cycle occupancy=0, out_valid=0, and 32'hF never appears.
- Mid-stream reset: occupancy=2, pulse reset low between clock edges -> out_valid drops to 0 immediately, out_data=RESET_VAL, and no stale word emerges after release.
